// File: rtl/dense_4_serial_mac.sv
// rtl/dense_4_serial_mac.sv - serial 32->5 dense layer with 5 parallel MAC lanes and saturated outputs.
// Optional ReLU on the outputs is enabled by defining DENSE4_SERIAL_RELU_EN.
package dense_4_23_12;
    localparam logic signed [22:0] bias [0:4] = '{-128, -129, -144, 168, 441};
    localparam logic signed [22:0] weights [0:31][0:4] = '{
        '{ -25,  646,  300,  -50,  700}, '{ 112, -340,   87,  415,  233},
        '{-501,   78, -260,   39,  512}, '{ 267, -133,  444, -318,  -97},
        '{  45,  390,  -72,  128,  861}, '{-198,  -57,  301,  226,  140},
        '{ 623,  210, -415,  -88, -355}, '{ -36, -477,  159,  502,  678},
        '{ 289,   95,   33, -241,   59}, '{-410,  188, -126,  367,  402},
        '{  74, -299,  518,  -19, -210}, '{ 156,  433, -387,   84,  917},
        '{-263,   11,  205, -456,  321}, '{ 391, -164,  -48,  273,   66},
        '{ -87,  352,  129, -134,  745}, '{ 220,  -81, -302,  410, -142},
        '{-344,  276,   91,   57,  288}, '{  18, -412,  367, -205,  534},
        '{ 507,   63, -189,  138,   12}, '{-129,  240,   76,  331, -488},
        '{  63,   -7, -451,  -92,  199}, '{-276,  318,  260,  189,  610},
        '{ 341, -226,  -17, -377,   83}, '{ -52,  145,  402,   46,  377},
        '{ 198, -368, -233,  295,  -61}, '{-415,   27,  118, -163,  842},
        '{  86,  459, -299,   72,  150}, '{ 233, -101,   64, -288,  467},
        '{-167,  284, -345,  411,  -23}, '{ 402,  -46,  187,  -59,  301},
        '{-310,  173,  -92,  236,  556}, '{ 127, -259,  331, -117,   92}
    };
endpackage

module dense_4_serial_mac #(
    parameter int WIDTH = 23,
    parameter int NFRAC = 11,
    parameter int N_IN  = 32,
    parameter int N_OUT = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WIDTH-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_OUT*WIDTH-1:0]   out_data
);
    localparam int KW = $clog2(N_IN);
    localparam int PW = 2 * WIDTH;
    localparam int AW = PW + KW;
    localparam logic signed [AW-1:0] SAT_MAX = AW'((longint'(1) <<< (WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - AW'(1);

    typedef enum logic [1:0] {ACCUM, FINAL, OUTPUT} state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic signed [AW-1:0]   acc_q [N_OUT];
    logic signed [AW-1:0]   acc_d [N_OUT];
    logic [N_OUT*WIDTH-1:0] out_data_q, out_data_d;

    function automatic logic signed [AW-1:0] bias_init(input int j);
        logic signed [AW-1:0] ext;
        ext = AW'(dense_4_23_12::bias[j]);
        return ext <<< NFRAC;
    endfunction

    function automatic logic signed [AW-1:0] product(input logic signed [WIDTH-1:0] x,
                                                     input logic signed [WIDTH-1:0] w);
        logic signed [PW-1:0] p;
        p = PW'(x) * PW'(w);
        return AW'(p);
    endfunction

    // Arithmetic shift floors toward -inf before clamping to the output range.
    function automatic logic [WIDTH-1:0] finalize(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        logic [WIDTH-1:0]     r;
        s = a >>> NFRAC;
        if (s > SAT_MAX) begin
            r = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (s < SAT_MIN) begin
            r = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            r = s[WIDTH-1:0];
        end
`ifdef DENSE4_SERIAL_RELU_EN
        if (r[WIDTH-1]) begin
            r = '0;
        end
`endif
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = !reset;
                if (in_valid) begin
                    for (int j = 0; j < N_OUT; j++) begin
                        acc_d[j] = acc_q[j] + product(in_data, dense_4_23_12::weights[k_q][j]);
                    end
                    if (k_q == KW'(N_IN - 1)) begin
                        k_d     = '0;
                        state_d = FINAL;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            FINAL: begin
                for (int j = 0; j < N_OUT; j++) begin
                    out_data_d[j*WIDTH +: WIDTH] = finalize(acc_q[j]);
                end
                state_d = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                // Bias preload on release means the next inference needs no extra add cycle.
                if (out_ready) begin
                    for (int j = 0; j < N_OUT; j++) begin
                        acc_d[j] = bias_init(j);
                    end
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACCUM;
            k_q        <= '0;
            out_data_q <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                acc_q[j] <= bias_init(j);
            end
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            out_data_q <= out_data_d;
            for (int j = 0; j < N_OUT; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

    assign out_data = out_data_q;

endmodule

// File: tb/tb_dense_4_serial_mac.sv
// tb/tb_dense_4_serial_mac.sv - directed and randomized bench for dense_4_serial_mac against an arithmetic model.
module tb_dense_4_serial_mac;
    localparam int W  = 23;
    localparam int NI = 32;
    localparam int NO = 5;

    typedef logic signed [W-1:0] vec_t [NI];

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [NO*W-1:0]    out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dense_4_serial_mac dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Real-valued dot product in integer units: scale bias by 2^11, floor-divide the sum by 2^11, clamp.
    function automatic logic [NO*W-1:0] model(input vec_t f);
        logic [NO*W-1:0] r;
        longint          s;
        for (int j = 0; j < NO; j++) begin
            s = longint'(dense_4_23_12::bias[j]) * 2048;
            for (int k = 0; k < NI; k++) begin
                s += longint'(f[k]) * longint'(dense_4_23_12::weights[k][j]);
            end
            s = s >>> 11;
            if (s > 4194303) s = 4194303;
            if (s < -4194304) s = -4194304;
`ifdef DENSE4_SERIAL_RELU_EN
            if (s < 0) s = 0;
`endif
            r[j*W +: W] = W'(s);
        end
        return r;
    endfunction

    function automatic logic [NO*W-1:0] pack(input int a [NO]);
        logic [NO*W-1:0] r;
        for (int j = 0; j < NO; j++) r[j*W +: W] = W'(a[j]);
        return r;
    endfunction

    task automatic check_vec(input string tag, input logic [NO*W-1:0] got, input logic [NO*W-1:0] exp);
        for (int j = 0; j < NO; j++) begin
            chk($sformatf("%s_lane%0d", tag, j), $signed(got[j*W +: W]), $signed(exp[j*W +: W]));
        end
    endtask

    task automatic feed(input vec_t f, input int n, input int gap_pct, input bit early_ready);
        int budget;
        for (int k = 0; k < n; k++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid  = 1'b1;
            in_data   = f[k];
            out_ready = early_ready;
            budget = 0;
            while (!in_ready && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (!in_ready) chk("in_ready_timeout", in_ready, 1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic infer(input vec_t f, input int gap_pct, input int hold, input bit early_ready,
                         output logic [NO*W-1:0] res);
        feed(f, NI, gap_pct, early_ready);
        chk("final_out_valid_low", out_valid, 0);
        chk("final_in_ready_low", in_ready, 0);
        @(negedge clk);
        chk("latency_out_valid", out_valid, 1);
        res = out_data;
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            @(negedge clk);
            chk("hold_data_stable", out_data === res, 1);
            chk("hold_in_ready_low", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid_low", out_valid, 0);
    endtask

    initial begin
        vec_t            f, z;
        logic [NO*W-1:0] res, res2, exp;
        int              v;
        int exp_zero [NO];
        int exp_hot  [NO];
`ifdef DENSE4_SERIAL_RELU_EN
        exp_zero = '{0, 0, 0, 168, 441};
        exp_hot  = '{0, 517, 156, 118, 1141};
`else
        exp_zero = '{-128, -129, -144, 168, 441};
        exp_hot  = '{-153, 517, 156, 118, 1141};
`endif
        for (int k = 0; k < NI; k++) z[k] = '0;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data === '0, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);

        infer(z, 0, 0, 1'b0, res);
        check_vec("zeros", res, pack(exp_zero));

        f = z; f[0] = 23'sd2048;
        infer(f, 0, 0, 1'b0, res);
        check_vec("onehot", res, pack(exp_hot));

        for (int k = 0; k < NI; k++) f[k] = (dense_4_23_12::weights[k][4] > 0) ? 23'h3FFFFF : '0;
        infer(f, 0, 0, 1'b0, res);
        chk("sat_pos_lane4", $signed(res[4*W +: W]), 4194303);
        check_vec("sat_pos", res, model(f));
        for (int k = 0; k < NI; k++) f[k] = (dense_4_23_12::weights[k][4] > 0) ? 23'h400000 : '0;
        infer(f, 0, 0, 1'b0, res);
`ifdef DENSE4_SERIAL_RELU_EN
        chk("sat_neg_lane4", $signed(res[4*W +: W]), 0);
`else
        chk("sat_neg_lane4", $signed(res[4*W +: W]), -4194304);
`endif
        check_vec("sat_neg", res, model(f));

        for (int k = 0; k < NI; k++) begin
            v = int'($urandom_range(8191)) - 4096;
            f[k] = W'(v);
        end
        infer(f, 0, 0, 1'b0, res);
        infer(f, 40, 10, 1'b1, res2);
        chk("gaps_equal_contiguous", res2 === res, 1);
        check_vec("gaps", res2, model(f));
        infer(z, 0, 0, 1'b0, res);
        check_vec("after_hold_bias", res, pack(exp_zero));

        for (int k = 0; k < NI; k++) f[k] = W'($urandom);
        feed(f, 17, 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_in_ready", in_ready, 0);
        chk("mid_reset_out_valid", out_valid, 0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("after_reset_out_valid", out_valid, 0);
        end
        infer(z, 0, 0, 1'b0, res);
        check_vec("reset_cleared", res, pack(exp_zero));

        for (int n = 0; n < 100; n++) begin
            for (int k = 0; k < NI; k++) begin
                if (n % 2 == 0) begin
                    v = int'($urandom_range(8191)) - 4096;
                    f[k] = W'(v);
                end else begin
                    f[k] = W'($urandom);
                end
            end
            exp = model(f);
            infer(f, (n % 4 == 3) ? 25 : 0, int'($urandom_range(2)), n[0], res);
            check_vec($sformatf("rand%0d", n), res, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dense_4_serial_mac.md
# dense_4_serial_mac

Sequential dense-layer engine for the final jet-tagging layer (32 inputs -> 5 class logits). It consumes features one per beat over a valid/ready stream and reads `weights` and `bias` from package `dense_4_23_12` (23-bit signed, 11 fractional bits). It keeps 5 parallel multiply-accumulate lanes. After the 32nd feature it presents all 5 saturated fixed-point results at once on an output valid/ready port to the downstream softmax/argmax stage.

## Interface
- `WIDTH`, 23: data, weight and bias width (signed two's complement).
- `NFRAC`, 11: fractional bits of data, weights and bias.
- `N_IN`, 32: features per inference; must match package row count.
- `N_OUT`, 5: output lanes; must match package column count.
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: feature beat valid.
- `in_ready` output 1: block accepts a feature this cycle.
- `in_data` input WIDTH: signed feature, index implied by beat order (0..N_IN-1).
- `out_valid` output 1: result vector valid.
- `out_ready` input 1: downstream accepts result.
- `out_data` output N_OUT*WIDTH: lane j at bits [j*WIDTH +: WIDTH], signed, NFRAC fractional bits.

## Operation
- FSM states: ACCUM, FINAL, OUTPUT.
- ACCUM:
  - `in_ready`=1.
  - On each handshake (`in_valid && in_ready`) at index k:
    - `acc[j] += in_data * weights[k][j]` for every lane j.
    - `k` increments.
  - Handshake with k = N_IN-1 moves the FSM to FINAL and sets k to 0.
- FINAL:
  - `in_ready`=0.
  - `out_data[j]` is registered as `sat(acc[j] >>> NFRAC)`, using an arithmetic shift (truncation toward -inf).
  - Moves unconditionally to OUTPUT.
- OUTPUT:
  - `out_valid`=1 and `out_data` is held stable until `out_ready`=1.
  - On that handshake: `acc[j]` reloads to `bias[j] <<< NFRAC`, and the FSM moves to ACCUM.
- Accumulator width is 2*WIDTH + clog2(N_IN) = 51 bits, signed. Accumulation never overflows.
- Saturation: results above 2^(WIDTH-1)-1 clamp to 23'h3FFFFF; results below -2^(WIDTH-1) clamp to 23'h400000.
- Bias is pre-loaded into the accumulators, so no extra cycle is spent adding it.
- Input gaps (`in_valid`=0) stall accumulation without penalty. The index advances only on a handshake.

## Timing
- Reset values:
  - state = ACCUM, k = 0.
  - `acc[j]` = `bias[j] <<< NFRAC`.
  - `in_ready`=0 during the reset cycle, then 1.
  - `out_valid`=0 and `out_data`=0.
- Latency: last feature accepted in cycle T -> FINAL in T+1 -> `out_valid`=1 in T+2.
- Minimum inference period: N_IN + 2 cycles with `out_ready` held at 1. Input and output never overlap.
- Back-pressure: while in OUTPUT, `in_ready`=0 regardless of `in_valid`. Features are not buffered.
- Reset asserted mid-operation (any state) discards partial sums and any pending result. Reset values apply the cycle after.
- `out_ready` asserted outside OUTPUT is ignored.
- Multiply is combinational into the accumulator register, so there is one accumulate per cycle and no multiplier pipeline.

## Configuration
- `DENSE4_SERIAL_RELU_EN`:
  - Defined: FINAL applies ReLU after saturation, so negative lane results become 0.
  - Undefined: raw signed saturated logits are output.
  - Latency is identical in both builds.

## Test plan
- 32 zero features, `out_ready`=1 -> `out_valid` exactly 2 cycles after the last beat.
  - Without ReLU: lanes = -128, -129, -144, 168, 441 (raw integer codes).
  - With `DENSE4_SERIAL_RELU_EN`: lanes = 0, 0, 0, 168, 441.
- One-hot input: feature 0 = 2048 (1.0), features 1..31 = 0 -> lane0 = -128 + (-25) = -153 and lane1 = -129 + 646 = 517. Lanes 2-4 equal bias plus row-0 weights.
- Saturation: feature k = 23'h3FFFFF where `weights[k][4]` > 0, else 0 -> lane4 = 23'h3FFFFF. Repeat with 23'h400000 -> lane4 clamps to 23'h400000 (or to 0 with ReLU).
- Back-pressure and gaps:
  - Random `in_valid` gaps give the same result as the contiguous stream.
  - `out_ready` held low for 10 cycles -> `out_data` stable, `in_ready`=0 throughout.
  - Next inference starts with bias-initialised accumulators.
- Reset after 17 accepted features -> `out_valid` stays 0. A following full all-zero inference returns the bias values, proving partial sums were cleared.
- Back-to-back random vectors against a golden model (same truncation and saturation), 100 inferences -> bit-exact match on all lanes.
